// File: rtl/qr_col_sched.sv
`default_nettype none
// qr_col_sched: feeds a column-shrinking element stream (ROWS, ROWS-1, ...) into a
// pipelined Givens cell and waits for every element to return before the next column.
module qr_col_sched #(
  parameter int INOUT_WIDTH = 16,
  parameter int ROWS        = 4,
  parameter int COLS        = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_in_valid,
  input  logic [2*INOUT_WIDTH-1:0]   i_in_data,
  output logic                       o_in_ready,
  output logic                       o_gg_valid,
  output logic [2*INOUT_WIDTH-1:0]   o_gg_data,
  output logic                       o_gg_first,
  output logic                       o_gg_last,
  input  logic                       i_gg_ret_valid,
  output logic [2:0]                 o_col_idx,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int             CW        = 4;
  localparam logic [CW-1:0]  ROWS_C    = CW'(ROWS);
  localparam logic [2:0]     COLS_LAST = 3'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 col_q, col_d;
  logic [CW-1:0]              issued_q, issued_d;
  logic [CW-1:0]              returned_q, returned_d;
  logic                       gg_valid_q, gg_valid_d;
  logic [2*INOUT_WIDTH-1:0]   gg_data_q, gg_data_d;
  logic                       gg_first_q, gg_first_d;
  logic                       gg_last_q, gg_last_d;

  logic [CW-1:0]              n_cur;
  logic                       in_ready;
  logic                       accept;
  logic                       ret_en;

  // Column c carries ROWS-c elements (the triangle below the diagonal shrinks).
  assign n_cur    = ROWS_C - {1'b0, col_q};
  assign in_ready = (state_q == S_FEED) && (issued_q < n_cur);
  assign accept   = i_in_valid && in_ready;
  assign ret_en   = i_gg_ret_valid && ((state_q == S_FEED) || (state_q == S_DRAIN));

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    gg_valid_d = 1'b0;
    gg_data_d  = gg_data_q;
    gg_first_d = 1'b0;
    gg_last_d  = 1'b0;

    if (accept) begin
      issued_d   = issued_q + CW'(1);
      gg_valid_d = 1'b1;
      gg_data_d  = i_in_data;
      gg_first_d = (issued_q == '0);
      gg_last_d  = (issued_q == n_cur - CW'(1));
    end

    // Returns are counted in FEED too, so a pulse coinciding with the final accept is kept.
    if (ret_en && (returned_q < n_cur)) begin
      returned_d = returned_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_FEED;
          col_d      = 3'd0;
          issued_d   = '0;
          returned_d = '0;
        end
      end
      S_FEED: begin
        if (accept && (issued_q == n_cur - CW'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (returned_q == n_cur) begin
          if (col_q < COLS_LAST) begin
            state_d    = S_FEED;
            col_d      = col_q + 3'd1;
            issued_d   = '0;
            returned_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including an element accepted this cycle.
    if (i_abort) begin
      state_d    = S_IDLE;
      col_d      = 3'd0;
      issued_d   = '0;
      returned_d = '0;
      gg_valid_d = 1'b0;
      gg_first_d = 1'b0;
      gg_last_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      col_q      <= 3'd0;
      issued_q   <= '0;
      returned_q <= '0;
      gg_valid_q <= 1'b0;
      gg_data_q  <= '0;
      gg_first_q <= 1'b0;
      gg_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      gg_valid_q <= gg_valid_d;
      gg_data_q  <= gg_data_d;
      gg_first_q <= gg_first_d;
      gg_last_q  <= gg_last_d;
    end
  end

  assign o_in_ready = in_ready;
  assign o_gg_valid = gg_valid_q;
  assign o_gg_data  = gg_data_q;
  assign o_gg_first = gg_first_q;
  assign o_gg_last  = gg_last_q;
  assign o_col_idx  = col_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_qr_col_sched.sv
`default_nettype none
// Directed bench for qr_col_sched (ROWS=COLS=4): full matrices, random valid, abort, reset.
module tb_qr_col_sched;

  localparam int W    = 16;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NTOT = 10;  // 4+3+2+1

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic            i_abort = 1'b0;
  logic            i_in_valid = 1'b0;
  logic [2*W-1:0]  i_in_data = '0;
  logic            o_in_ready;
  logic            o_gg_valid;
  logic [2*W-1:0]  o_gg_data;
  logic            o_gg_first;
  logic            o_gg_last;
  logic            i_gg_ret_valid = 1'b0;
  logic [2:0]      o_col_idx;
  logic            o_busy;
  logic            o_done;

  int total = 0;
  int bad   = 0;

  qr_col_sched #(.INOUT_WIDTH(W), .ROWS(ROWS), .COLS(COLS)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_in_valid     (i_in_valid),
    .i_in_data      (i_in_data),
    .o_in_ready     (o_in_ready),
    .o_gg_valid     (o_gg_valid),
    .o_gg_data      (o_gg_data),
    .o_gg_first     (o_gg_first),
    .o_gg_last      (o_gg_last),
    .i_gg_ret_valid (i_gg_ret_valid),
    .o_col_idx      (o_col_idx),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  // Issue number k -> (column, index within column) for the shrinking column sizes.
  function automatic void issue_pos(input int k, output int c, output int idx);
    c   = 0;
    idx = k;
    while (idx >= ROWS - c) begin
      idx -= ROWS - c;
      c++;
    end
  endfunction

  task automatic check_all_zero(input string nm);
    total++;
    if ({o_in_ready, o_gg_valid, o_gg_first, o_gg_last, o_busy, o_done, o_col_idx} !== 9'd0) begin
      bad++;
      $display("FAIL %s ctrl: got rdy=%b v=%b f=%b l=%b busy=%b done=%b col=%0d want all 0", nm,
               o_in_ready, o_gg_valid, o_gg_first, o_gg_last, o_busy, o_done, o_col_idx);
    end
    total++;
    if (o_gg_data !== '0) begin
      bad++;
      $display("FAIL %s data: got %h want 0", nm, o_gg_data);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_in_valid = 1'b1;
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    i_in_valid = 1'b0;
    i_start = 1'b0;
    i_rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_release");
  endtask

  // One full matrix; returns arrive dly cycles after each observed issue.
  task automatic run_matrix(input int dly, input bit rnd, input string nm);
    int          cyc = 0;
    int          nissue = 0;
    int          nret = 0;
    int          dones = 0;
    bit          exp_v = 1'b0;
    logic [31:0] exp_q[$];
    int          pend[$];
    logic [31:0] dctr;
    logic [31:0] ed;
    int          c, idx;
    dctr = 32'h5A00_0000 + 32'($urandom_range(0, 255)) * 32'h100;
    @(negedge clk);
    i_start = 1'b1;
    while (dones == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        total++;
        if (o_busy !== 1'b1 || o_col_idx !== 3'd0) begin
          bad++;
          $display("FAIL %s start: got busy=%b col=%0d want busy=1 col=0", nm, o_busy, o_col_idx);
        end
      end
      total++;
      if (o_gg_valid !== exp_v) begin
        bad++;
        $display("FAIL %s gg_valid cyc%0d: got %b want %b", nm, cyc, o_gg_valid, exp_v);
      end
      if (o_gg_valid === 1'b1 && exp_v) begin
        ed = exp_q.pop_front();
        issue_pos(nissue, c, idx);
        total++;
        if (o_gg_data !== ed) begin
          bad++;
          $display("FAIL %s data#%0d: got %h want %h", nm, nissue, o_gg_data, ed);
        end
        total++;
        if (o_gg_first !== (idx == 0) || o_gg_last !== (idx == ROWS - c - 1)) begin
          bad++;
          $display("FAIL %s flags#%0d: got f=%b l=%b want f=%b l=%b", nm, nissue,
                   o_gg_first, o_gg_last, (idx == 0), (idx == ROWS - c - 1));
        end
        total++;
        if (o_col_idx !== 3'(c)) begin
          bad++;
          $display("FAIL %s col#%0d: got %0d want %0d", nm, nissue, o_col_idx, c);
        end
        nissue++;
        pend.push_back(cyc + dly);
      end
      if (o_done === 1'b1) begin
        dones++;
        total++;
        if (nret != NTOT || o_col_idx !== 3'(COLS - 1)) begin
          bad++;
          $display("FAIL %s done: got returns=%0d col=%0d want %0d col=%0d", nm, nret, o_col_idx,
                   NTOT, COLS - 1);
        end
      end
      // Restarts are held off the bus well before the matrix can finish.
      i_start    = rnd && (cyc < 6);
      i_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_in_data  = dctr;
      exp_v      = i_in_valid && (o_in_ready === 1'b1);
      if (exp_v) begin
        exp_q.push_back(dctr);
        dctr++;
      end
      if (pend.size() > 0 && pend[0] <= cyc) begin
        void'(pend.pop_front());
        i_gg_ret_valid = 1'b1;
        nret++;
      end else begin
        i_gg_ret_valid = 1'b0;
      end
    end
    i_start = 1'b0;
    i_in_valid = 1'b0;
    i_gg_ret_valid = 1'b0;
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL %s done_seen: got %0d want 1 (cycles %0d)", nm, dones, cyc);
    end
    total++;
    if (nissue != NTOT) begin
      bad++;
      $display("FAIL %s issues: got %0d want %0d", nm, nissue, NTOT);
    end
    @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_col_idx !== 3'(COLS - 1)) begin
      bad++;
      $display("FAIL %s idle: got busy=%b done=%b col=%0d want 0 0 %0d", nm, o_busy, o_done,
               o_col_idx, COLS - 1);
    end
  endtask

  task automatic test_full_matrix();
    run_matrix(10, 1'b0, "full_d10");
  endtask

  task automatic test_coincident_return();
    run_matrix(0, 1'b0, "coincident");
  endtask

  task automatic test_random_valid();
    run_matrix(3, 1'b1, "random_a");
    run_matrix(7, 1'b1, "random_b");
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      i_in_valid = 1'b1;
      i_gg_ret_valid = o_gg_valid;
      if (o_col_idx === 3'd2 && o_in_ready === 1'b1) begin
        i_abort = 1'b1;
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL abort_reach_col2: got not reached want reached");
    end
    @(negedge clk);
    i_abort = 1'b0;
    i_in_valid = 1'b0;
    i_gg_ret_valid = 1'b0;
    total++;
    if (o_gg_valid !== 1'b0 || o_busy !== 1'b0 || o_col_idx !== 3'd0 || o_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_next: got v=%b busy=%b col=%0d rdy=%b want 0 0 0 0", o_gg_valid,
               o_busy, o_col_idx, o_in_ready);
    end
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL start_with_abort: got busy=%b want 0", o_busy);
    end
    run_matrix(2, 1'b0, "after_abort");
  endtask

  task automatic test_reset_in_drain();
    bit found = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      i_in_valid = 1'b1;
      @(negedge clk);
      if (o_busy === 1'b1 && o_in_ready === 1'b0) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL drain_reach: got not reached want reached");
    end
    i_in_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    check_all_zero("rst_in_drain");
    @(negedge clk);
    i_rst = 1'b0;
    run_matrix(10, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_full_matrix();
    test_coincident_return();
    test_random_valid();
    test_abort();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
